// File: rtl/free_list.sv
// free_list -- circular FIFO of free physical register tags for a rename stage.
//
// The head entry is always presented on p_rd_new; the map table consumes it
// whenever a destination-writing instruction dispatches (alloc). Tags come
// back from two sources: the old mapping of a retiring instruction, or the
// new mapping of an instruction flushed during recovery. Recovery has priority
// over retire when both present a tag in the same cycle.
//
// Ports
//   clk               in   sole clock, rising edge
//   rst               in   synchronous reset, active low
//   hazard_stall      in   dispatch stalled by hazard logic
//   RegDest           in   dispatching instruction writes a destination
//   recover           in   recovery in progress (blocks allocation)
//   retire_PR[5:0]    in   tag freed at retire
//   retire_valid      in   retire_PR valid
//   recover_PR[5:0]   in   tag released by a flushed instruction
//   recover_PR_valid  in   recover_PR valid
//   p_rd_new[5:0]     out  head entry (don't-care when free_empty)
//   free_empty        out  no free tags (registered count == 0)
//   free_count[5:0]   out  registered number of free tags, 0..DEPTH
//   fl_err            out  sticky error: underflow, overflow or double push
module free_list #(
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hazard_stall,
    input  logic       RegDest,
    input  logic       recover,
    input  logic [5:0] retire_PR,
    input  logic       retire_valid,
    input  logic [5:0] recover_PR,
    input  logic       recover_PR_valid,
    output logic [5:0] p_rd_new,
    output logic       free_empty,
    output logic [5:0] free_count,
    output logic       fl_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [5:0]    entry_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [5:0]    count_q, count_d;
    logic          err_q, err_d;

    logic          alloc;
    logic          push_req;
    logic [5:0]    push_pr;
    logic          pop_ok;
    logic          push_ok;
    logic          underflow;
    logic          overflow;
    logic          dual_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        alloc     = RegDest && !hazard_stall && !recover;
        push_req  = recover_PR_valid || retire_valid;
        push_pr   = recover_PR_valid ? recover_PR : retire_PR;
        dual_push = recover_PR_valid && retire_valid;

        underflow = alloc && (count_q == 6'd0);
        pop_ok    = alloc && (count_q != 6'd0);
        // A full list can still accept a tag when a pop frees a slot this cycle.
        overflow  = push_req && (count_q == 6'(DEPTH)) && !pop_ok;
        push_ok   = push_req && !overflow;

        head_d  = pop_ok  ? ptr_inc(head_q) : head_q;
        tail_d  = push_ok ? ptr_inc(tail_q) : tail_q;
        count_d = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + 6'd1;
        else if (pop_ok && !push_ok)
            count_d = count_q - 6'd1;

        err_d = err_q || underflow || overflow || dual_push;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                entry_q[i] <= 6'(32 + i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 6'(DEPTH);
            err_q   <= 1'b0;
        end else begin
            if (push_ok)
                entry_q[tail_q] <= push_pr;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign p_rd_new   = entry_q[head_q];
    assign free_empty = (count_q == 6'd0);
    assign free_count = count_q;
    assign fl_err     = err_q;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list. The stimulus process drives one cycle at a
// time and queues the state expected after that edge; the monitor samples the
// outputs on the falling edge and compares against the queued expectation.
module tb_free_list;

    logic       clk = 1'b0;
    logic       rst;
    logic       hazard_stall;
    logic       RegDest;
    logic       recover;
    logic [5:0] retire_PR;
    logic       retire_valid;
    logic [5:0] recover_PR;
    logic       recover_PR_valid;
    logic [5:0] p_rd_new;
    logic       free_empty;
    logic [5:0] free_count;
    logic       fl_err;

    free_list #(.DEPTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .hazard_stall     (hazard_stall),
        .RegDest          (RegDest),
        .recover          (recover),
        .retire_PR        (retire_PR),
        .retire_valid     (retire_valid),
        .recover_PR       (recover_PR),
        .recover_PR_valid (recover_PR_valid),
        .p_rd_new         (p_rd_new),
        .free_empty       (free_empty),
        .free_count       (free_count),
        .fl_err           (fl_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] prd;
        logic       chk_prd;
        logic       empty;
        logic [5:0] cnt;
        logic       err;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic check(input string nm, input string fld, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
    endtask

    // Monitor: the registered outputs are stable by the falling edge.
    exp_t  cur;
    string cur_nm;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur    = exp_q.pop_front();
            cur_nm = name_q.pop_front();
            if (cur.chk_prd) check(cur_nm, "p_rd_new", int'(p_rd_new), int'(cur.prd));
            check(cur_nm, "free_empty", int'(free_empty), int'(cur.empty));
            check(cur_nm, "free_count", int'(free_count), int'(cur.cnt));
            check(cur_nm, "fl_err",     int'(fl_err),     int'(cur.err));
        end
    end

    // One clock: apply inputs, take the edge, queue the expected post-edge state.
    task automatic cyc(input logic r, input logic hz, input logic rd, input logic rc,
                       input logic rtv, input logic [5:0] rtp,
                       input logic rcv, input logic [5:0] rcp,
                       input logic [5:0] e_prd, input logic e_chk, input logic e_empty,
                       input logic [5:0] e_cnt, input logic e_err, input string nm);
        exp_t e;
        rst = r; hazard_stall = hz; RegDest = rd; recover = rc;
        retire_valid = rtv; retire_PR = rtp;
        recover_PR_valid = rcv; recover_PR = rcp;
        @(posedge clk);
        #1;
        e.prd = e_prd; e.chk_prd = e_chk; e.empty = e_empty; e.cnt = e_cnt; e.err = e_err;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // 32 allocations from a freshly reset list: head walks 32..63 then empties.
    task automatic drain_from_reset(input string nm);
        for (int i = 0; i < 32; i++) begin
            if (i < 31) cyc(1, 0, 1, 0, 0, 6'd0, 0, 6'd0, 6'(33 + i), 1, 0, 6'(31 - i), 0, nm);
            else        cyc(1, 0, 1, 0, 0, 6'd0, 0, 6'd0, 6'd0,       0, 1, 6'd0,       0, nm);
        end
    endtask

    initial begin
        int budget;
        // reset state
        cyc(0, 0, 0, 0, 0, 6'd0, 0, 6'd0, 6'd32, 1, 0, 6'd32, 0, "reset");
        drain_from_reset("alloc32");

        // refill from empty with a retired tag
        cyc(1, 0, 0, 0, 1, 6'd5, 0, 6'd0, 6'd5, 1, 0, 6'd1, 0, "retire_from_empty");
        // build up to count 10: queue = 5,10..18
        for (int i = 0; i < 9; i++)
            cyc(1, 0, 0, 0, 1, 6'(10 + i), 0, 6'd0, 6'd5, 1, 0, 6'(2 + i), 0, "fill10");
        // alloc + retire 7 together: 5 leaves, 7 joins at the tail
        cyc(1, 0, 1, 0, 1, 6'd7, 0, 6'd0, 6'd10, 1, 0, 6'd10, 0, "pop_push");
        for (int i = 0; i < 8; i++)
            cyc(1, 0, 1, 0, 0, 6'd0, 0, 6'd0, 6'(11 + i), 1, 0, 6'(9 - i), 0, "drain_old");
        cyc(1, 0, 1, 0, 0, 6'd0, 0, 6'd0, 6'd7, 1, 0, 6'd1, 0, "seven_last");
        cyc(1, 0, 1, 0, 0, 6'd0, 0, 6'd0, 6'd0, 0, 1, 6'd0, 0, "empty_again");

        // recovery blocks allocation while pushing the flushed tag
        cyc(1, 0, 1, 1, 0, 6'd0, 1, 6'd40, 6'd40, 1, 0, 6'd1, 0, "recover_push");
        cyc(1, 0, 1, 0, 0, 6'd0, 0, 6'd0, 6'd0, 0, 1, 6'd0, 0, "pop40");
        // both sources valid: recover wins, error flagged
        cyc(1, 0, 0, 0, 1, 6'd3, 1, 6'd4, 6'd4, 1, 0, 6'd1, 1, "dual_push");

        // reset wins over concurrent recovery/push/pop activity
        cyc(0, 0, 1, 1, 1, 6'd9, 1, 6'd50, 6'd32, 1, 0, 6'd32, 0, "reset_mid_recover");
        // stalled dispatch does not pop
        cyc(1, 1, 1, 0, 0, 6'd0, 0, 6'd0, 6'd32, 1, 0, 6'd32, 0, "hazard_stall");
        // full list: a pop makes room for the push
        cyc(1, 0, 1, 0, 1, 6'd12, 0, 6'd0, 6'd33, 1, 0, 6'd32, 0, "full_pop_push");
        // full list, no pop: push dropped, error set
        cyc(1, 0, 0, 0, 1, 6'd6, 0, 6'd0, 6'd33, 1, 0, 6'd32, 1, "overflow");
        // invalid tags ignored; error sticky
        cyc(1, 0, 0, 0, 0, 6'd21, 0, 6'd22, 6'd33, 1, 0, 6'd32, 1, "sticky_err");
        cyc(0, 0, 0, 0, 0, 6'd0, 0, 6'd0, 6'd32, 1, 0, 6'd32, 0, "reset_clears_err");

        // underflow with a concurrent push: push proceeds, head holds
        drain_from_reset("alloc32_b");
        cyc(1, 0, 1, 0, 1, 6'd9, 0, 6'd0, 6'd9, 1, 0, 6'd1, 1, "underflow_push");
        cyc(1, 0, 1, 0, 0, 6'd0, 0, 6'd0, 6'd0, 0, 1, 6'd0, 1, "pop_after_underflow");

        cyc(1, 0, 0, 0, 0, 6'd0, 0, 6'd0, 6'd0, 0, 1, 6'd0, 1, "idle");
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL monitor_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
